aes_key_schedule: RTL and testbench

Iterative AES-128 key expansion that feeds the AddRoundKey stage directly upstream of it. It latches a 128-bit cipher key on start and emits round keys 0..10 one at a time over a valid/ready handshake. The next key is computed on the fly, so no 11-entry key store is kept.

---
 rtl/aes_key_schedule_if.sv | 33 +++
 rtl/aes_key_schedule.sv | 181 ++++++++++++++++++
 tb/tb_aes_key_schedule.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_schedule_if.sv
// rtl/aes_key_schedule_if.sv - round key handshake bundle between key schedule and AddRoundKey
// The decrypt request line exists only when AES_KEY_SCHED_DECRYPT_EN is defined.
interface aes_key_schedule_if #(
  parameter int KW = 128
);
  logic          start;
  logic [KW-1:0] key_in;
  logic          rk_ready;
  logic [KW-1:0] round_key;
  logic [3:0]    round_idx;
  logic          rk_valid;
  logic          busy;
  logic          done;
`ifdef AES_KEY_SCHED_DECRYPT_EN
  logic          decrypt;
`endif

  modport master (
`ifdef AES_KEY_SCHED_DECRYPT_EN
    output decrypt,
`endif
    output start, key_in, rk_ready,
    input  round_key, round_idx, rk_valid, busy, done
  );

  modport slave (
`ifdef AES_KEY_SCHED_DECRYPT_EN
    input  decrypt,
`endif
    input  start, key_in, rk_ready,
    output round_key, round_idx, rk_valid, busy, done
  );
endinterface

// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - iterative AES-128 key expansion emitting round keys 0..NR on valid/ready
// Define AES_KEY_SCHED_DECRYPT_EN to add reverse-order emission (round NR down to 0).
module aes_key_schedule #(
  parameter int word_size  = 8,
  parameter int array_size = 16,
  parameter int NR         = 10
) (
  input  logic              clk,
  input  logic              rst,
  aes_key_schedule_if.slave ks
);
  localparam int         KW     = word_size * array_size;
  localparam logic [3:0] NR_IDX = 4'(NR);

`ifdef AES_KEY_SCHED_DECRYPT_EN
  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_PREP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_EMIT} state_t;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box: multiplicative inverse as a^254 (maps 0 to 0), then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = gf_mul(a, a);
    inv = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;  4'd4:  return 8'h08;
      4'd5: return 8'h10;  4'd6: return 8'h20;  4'd7: return 8'h40;  4'd8:  return 8'h80;
      4'd9: return 8'h1b;  4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] fwd_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w0 = w0 ^ sub_rot(w3) ^ {rc, 24'h0};
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo fwd_key: recover w3..w1 first, since the old w3 feeds the w0 term.
  function automatic logic [127:0] inv_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w3 = w3 ^ w2;
    w2 = w2 ^ w1;
    w1 = w1 ^ w0;
    w0 = w0 ^ sub_rot(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  state_t        state_q;
  logic [KW-1:0] round_key_q;
  logic [3:0]    round_idx_q;
  logic          rk_valid_q;
  logic          busy_q;
  logic          done_q;
`ifdef AES_KEY_SCHED_DECRYPT_EN
  logic          dec_q;
`endif

  logic [KW-1:0] fwd_key_d;
  logic [KW-1:0] step_key_d;
  logic [3:0]    step_idx_d;
  logic          last_d;

  always_comb begin
    fwd_key_d  = fwd_key(round_key_q, rcon(round_idx_q + 4'd1));
    step_key_d = fwd_key_d;
    step_idx_d = round_idx_q + 4'd1;
    last_d     = (round_idx_q == NR_IDX);
`ifdef AES_KEY_SCHED_DECRYPT_EN
    if (dec_q) begin
      step_key_d = inv_key(round_key_q, rcon(round_idx_q));
      step_idx_d = round_idx_q - 4'd1;
      last_d     = (round_idx_q == 4'd0);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      round_key_q <= '0;
      round_idx_q <= 4'd0;
      rk_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef AES_KEY_SCHED_DECRYPT_EN
      dec_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ks.start) begin
            round_key_q <= ks.key_in;
            round_idx_q <= 4'd0;
            busy_q      <= 1'b1;
`ifdef AES_KEY_SCHED_DECRYPT_EN
            dec_q <= ks.decrypt;
            if (ks.decrypt) begin
              state_q <= S_PREP;
            end else begin
              rk_valid_q <= 1'b1;
              state_q    <= S_EMIT;
            end
`else
            rk_valid_q <= 1'b1;
            state_q    <= S_EMIT;
`endif
          end
        end
`ifdef AES_KEY_SCHED_DECRYPT_EN
        // Walk forward to the last round key before emitting in reverse.
        S_PREP: begin
          round_key_q <= fwd_key_d;
          round_idx_q <= round_idx_q + 4'd1;
          if (round_idx_q == NR_IDX - 4'd1) begin
            rk_valid_q <= 1'b1;
            state_q    <= S_EMIT;
          end
        end
`endif
        S_EMIT: begin
          if (ks.rk_ready) begin
            if (last_d) begin
              rk_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              round_key_q <= step_key_d;
              round_idx_q <= step_idx_d;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ks.round_key = round_key_q;
  assign ks.round_idx = round_idx_q;
  assign ks.rk_valid  = rk_valid_q;
  assign ks.busy      = busy_q;
  assign ks.done      = done_q;
endmodule

// File: tb/tb_aes_key_schedule.sv
// tb/tb_aes_key_schedule.sv - scoreboard bench for aes_key_schedule against a FIPS-197 word-expansion model
// Reverse-order cases are exercised when AES_KEY_SCHED_DECRYPT_EN is defined.
module tb_aes_key_schedule;
  localparam int NR = 10;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  aes_key_schedule_if ks ();

  aes_key_schedule dut (
    .clk (clk),
    .rst (rst),
    .ks  (ks)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
    bit           last;
  } exp_t;

  exp_t         scb[$];
  logic [7:0]   sb_tab [0:255];
  logic [7:0]   rcon_tab [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [127:0] ref_keys [0:10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Carry-less product followed by reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b + 4) % 8] ^ inv[(b + 5) % 8] ^ inv[(b + 6) % 8]
                      ^ inv[(b + 7) % 8] ^ c[b];
      sb_tab[x] = s;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]}
            ^ {rcon_tab[i / 4], 24'h0};
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r <= NR; r++)
      ref_keys[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  task automatic push_exp(input bit dec);
    exp_t e;
    for (int r = 0; r <= NR; r++) begin
      e.idx  = dec ? 4'(NR - r) : 4'(r);
      e.key  = ref_keys[e.idx];
      e.last = (r == NR);
      scb.push_back(e);
    end
  endtask

  // Monitor: pops one expectation per handshake, tracks done and hold stability.
  bit           exp_done;
  bit           nxt_done;
  bit           prev_hold;
  logic [127:0] prev_key;
  logic [3:0]   prev_idx;
  exp_t         got;

  always @(negedge clk) begin
    if (rst) begin
      nxt_done = 1'b0;
      chk("done_pulse", ks.done, exp_done);
      if (ks.done && ks.rk_valid) chk("done_with_valid", 1'b1, 1'b0);
      if (prev_hold) begin
        chk("hold_valid", ks.rk_valid, 1'b1);
        chk("hold_key", ks.round_key, prev_key);
        chk("hold_idx", ks.round_idx, prev_idx);
      end
      if (ks.rk_valid && ks.rk_ready) begin
        if (scb.size() == 0) begin
          chk("unexpected_handshake", 1'b1, 1'b0);
        end else begin
          got = scb.pop_front();
          chk("round_idx", ks.round_idx, got.idx);
          chk("round_key", ks.round_key, got.key);
          nxt_done = got.last;
        end
      end
      prev_hold = ks.rk_valid && !ks.rk_ready;
      prev_key  = ks.round_key;
      prev_idx  = ks.round_idx;
      exp_done  = nxt_done;
    end else begin
      exp_done  = 1'b0;
      prev_hold = 1'b0;
    end
  end

  task automatic run_seq(input logic [127:0] key, input bit dec, input bit rnd, input bit pulse);
    int n;
    int first_n;
    push_exp(dec);
    @(posedge clk); #1;
    ks.key_in   = key;
    ks.start    = 1'b1;
`ifdef AES_KEY_SCHED_DECRYPT_EN
    ks.decrypt  = dec;
`endif
    ks.rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    ks.start  = 1'b0;
    ks.key_in = ~key;
    n         = 0;
    first_n   = -1;
    while (!ks.done && n < 400) begin
      if (first_n < 0 && ks.rk_valid) first_n = n;
      ks.rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ks.start    = pulse && ks.rk_valid && (ks.round_idx == 4'd3 || ks.round_idx == 4'd10);
      @(posedge clk); #1;
      n++;
    end
    ks.start = 1'b0;
    chk("seq_done", ks.done, 1'b1);
    chk("first_valid_latency", first_n, dec ? NR : 0);
    if (!rnd) chk("stream_cycles", n, dec ? 2 * NR + 1 : NR + 1);
    chk("busy_after_done", ks.busy, 1'b0);
    chk("valid_after_done", ks.rk_valid, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", ks.busy, 1'b0);
    chk("idle_valid", ks.rk_valid, 1'b0);
    chk("scoreboard_empty", scb.size(), 0);
    scb.delete();
  endtask

  localparam logic [127:0] KA    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KA_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KA_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KB    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KB_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  task automatic load_a1();
    model_expand(KA);
    ref_keys[1]  = KA_1;
    ref_keys[10] = KA_10;
  endtask

  initial begin
    int n;
    tests = 0;
    fails = 0;
    build_sbox();
    rst         = 1'b0;
    ks.start    = 1'b0;
    ks.key_in   = '0;
    ks.rk_ready = 1'b0;
`ifdef AES_KEY_SCHED_DECRYPT_EN
    ks.decrypt  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_round_key", ks.round_key, 128'h0);
    chk("reset_round_idx", ks.round_idx, 4'd0);
    chk("reset_valid", ks.rk_valid, 1'b0);
    chk("reset_busy", ks.busy, 1'b0);
    chk("reset_done", ks.done, 1'b0);
    rst = 1'b1;

    load_a1(); run_seq(KA, 1'b0, 1'b0, 1'b0);
    load_a1(); run_seq(KA, 1'b0, 1'b1, 1'b0);
    load_a1(); run_seq(KA, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of the stream at round 5.
    load_a1();
    push_exp(1'b0);
    @(posedge clk); #1;
    ks.key_in   = KA;
    ks.start    = 1'b1;
    ks.rk_ready = 1'b1;
    @(posedge clk); #1;
    ks.start = 1'b0;
    n = 0;
    while (!(ks.rk_valid && ks.round_idx == 4'd5) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_round5", ks.round_idx, 4'd5);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_key", ks.round_key, 128'h0);
    chk("async_rst_idx", ks.round_idx, 4'd0);
    chk("async_rst_valid", ks.rk_valid, 1'b0);
    chk("async_rst_busy", ks.busy, 1'b0);
    chk("async_rst_done", ks.done, 1'b0);
    scb.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", ks.rk_valid, 1'b0);
    chk("post_rst_busy", ks.busy, 1'b0);
    load_a1(); run_seq(KA, 1'b0, 1'b1, 1'b0);

    model_expand(KB);
    ref_keys[10] = KB_10;
    run_seq(KB, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      logic [127:0] rk;
      rk = {$urandom, $urandom, $urandom, $urandom};
      model_expand(rk);
      run_seq(rk, 1'b0, 1'b1, 1'b0);
    end

`ifdef AES_KEY_SCHED_DECRYPT_EN
    load_a1(); run_seq(KA, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      logic [127:0] rk;
      rk = {$urandom, $urandom, $urandom, $urandom};
      model_expand(rk);
      run_seq(rk, 1'b1, 1'b1, 1'b0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end
endmodule
